// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared state encoding, default sizing and index-width helper for the FFT frame sequencer
package fft_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, UNLOAD} state_t;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_SEQ_LENGTH = 16;
  localparam int DEF_CORE_LATENCY = 64;
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: complex register bank with indexed write, full parallel load and indexed read
module fft_frame_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LENGTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [DATA_WIDTH-1:0]            wr_real,
  input  logic [DATA_WIDTH-1:0]            wr_img,
  input  logic                             load,
  input  logic [SEQ_LENGTH*DATA_WIDTH-1:0] ld_real,
  input  logic [SEQ_LENGTH*DATA_WIDTH-1:0] ld_img,
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic [DATA_WIDTH-1:0]            rd_real,
  output logic [DATA_WIDTH-1:0]            rd_img,
  output logic [SEQ_LENGTH*DATA_WIDTH-1:0] all_real,
  output logic [SEQ_LENGTH*DATA_WIDTH-1:0] all_img
);
  logic [SEQ_LENGTH-1:0][DATA_WIDTH-1:0] re, im;
  always_ff @(posedge clk)
    if (load) begin
      re <= ld_real;
      im <= ld_img;
    end else if (we) begin
      re[wr_idx] <= wr_real;
      im[wr_idx] <= wr_img;
    end
  assign rd_real = re[rd_idx];
  assign rd_img = im[rd_idx];
  assign all_real = re;
  assign all_img = im;
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: gathers a frame of samples, runs the FFT core for a fixed latency, then streams the bins out
module fft_frame_sequencer import fft_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEQ_LENGTH = DEF_SEQ_LENGTH,
  parameter int CORE_LATENCY = DEF_CORE_LATENCY,
  localparam int IW = idx_width(SEQ_LENGTH),
  localparam int FW = SEQ_LENGTH * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_real,
  input  logic [DATA_WIDTH-1:0] s_img,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_real,
  output logic [DATA_WIDTH-1:0] m_img,
  output logic [IW-1:0]         m_index,
  output logic                  m_last,
  output logic                  core_en,
  output logic [FW-1:0]         core_in_real,
  output logic [FW-1:0]         core_in_img,
  input  logic [FW-1:0]         core_out_real,
  input  logic [FW-1:0]         core_out_img,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int TW = idx_width(CORE_LATENCY);
  state_t state;
  logic [IW-1:0] wr_idx, rd_idx, rd_next;
  logic [TW-1:0] timer;
  logic [DATA_WIDTH-1:0] rd_real, rd_img, unused_rd_real, unused_rd_img;
  logic [FW-1:0] unused_all_real, unused_all_img;
  logic accept, take, last_wr, last_rd, run_done, advance;
  assign accept = s_valid && s_ready;
  assign take = m_valid && m_ready;
  assign last_wr = wr_idx == IW'(SEQ_LENGTH - 1);
  assign last_rd = rd_idx == IW'(SEQ_LENGTH - 1);
  assign run_done = timer == TW'(CORE_LATENCY - 1);
  assign rd_next = (state == UNLOAD) ? rd_idx + 1'b1 : '0;
  // CAPTURE presents bin 0; each non-final handshake presents the next bin
  assign advance = (state == CAPTURE) || (take && !last_rd);
  fft_frame_buffer #(.DATA_WIDTH(DATA_WIDTH), .SEQ_LENGTH(SEQ_LENGTH), .IDX_W(IW)) in_buf (
    .clk(clk), .we(accept), .wr_idx(wr_idx), .wr_real(s_real), .wr_img(s_img),
    .load(1'b0), .ld_real('0), .ld_img('0), .rd_idx('0),
    .rd_real(unused_rd_real), .rd_img(unused_rd_img), .all_real(core_in_real), .all_img(core_in_img)
  );
  fft_frame_buffer #(.DATA_WIDTH(DATA_WIDTH), .SEQ_LENGTH(SEQ_LENGTH), .IDX_W(IW)) out_buf (
    .clk(clk), .we(1'b0), .wr_idx('0), .wr_real('0), .wr_img('0),
    .load(state == RUN && run_done), .ld_real(core_out_real), .ld_img(core_out_img), .rd_idx(rd_next),
    .rd_real(rd_real), .rd_img(rd_img), .all_real(unused_all_real), .all_img(unused_all_img)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      wr_idx <= '0;
      rd_idx <= '0;
      timer <= '0;
      s_ready <= 1'b0;
      core_en <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_index <= '0;
      m_real <= '0;
      m_img <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          s_ready <= !(accept && last_wr);
          if (accept) begin
            wr_idx <= last_wr ? '0 : wr_idx + 1'b1;
            state <= last_wr ? RUN : LOAD;
            core_en <= last_wr;
            busy <= 1'b1;
            timer <= '0;
          end
        end
        RUN: begin
          timer <= run_done ? '0 : timer + 1'b1;
          if (run_done) begin
            state <= CAPTURE;
            core_en <= 1'b0;
          end
        end
        CAPTURE: state <= UNLOAD;
        UNLOAD:
          if (take && last_rd) begin
            state <= IDLE;
            m_valid <= 1'b0;
            rd_idx <= '0;
            wr_idx <= '0;
            frame_done <= 1'b1;
            s_ready <= 1'b1;
            busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
      if (advance) begin
        m_valid <= 1'b1;
        rd_idx <= rd_next;
        m_index <= rd_next;
        m_real <= rd_real;
        m_img <= rd_img;
        m_last <= rd_next == IW'(SEQ_LENGTH - 1);
      end
    end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: randomized scenario bench; expected bins come from a queue of accepted samples
module tb_fft_frame_sequencer;
  localparam int DW = 16;
  localparam int N = 16;
  localparam int L = 64;
  localparam int IW = 4;
  logic clk = 1'b0, reset_n = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic s_ready, m_valid, m_last, core_en, busy, frame_done;
  logic [DW-1:0] s_real = '0, s_img = '0, m_real, m_img;
  logic [IW-1:0] m_index;
  logic [N*DW-1:0] core_in_real, core_in_img, core_out_real, core_out_img;
  int errors = 0, checks = 0, cyc = 0, en_run = 0;
  int first_acc, last_acc, first_hs, en_cnt, s_ready_hi, core_in_bad, stall_bad, stall_idx, stall_cnt, fd_cnt;
  logic busy_start;
  logic [DW-1:0] exp_re[$], exp_im[$];
  logic [DW-1:0] frm_re[N], frm_im[N], got_re[N], got_im[N];
  logic [IW-1:0] got_idx[N];
  logic got_last[N];
  logic [N*DW-1:0] cin_re, cin_im;

  fft_frame_sequencer #(.DATA_WIDTH(DW), .SEQ_LENGTH(N), .CORE_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_img(s_img),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_img(m_img), .m_index(m_index), .m_last(m_last),
    .core_en(core_en), .core_in_real(core_in_real), .core_in_img(core_in_img),
    .core_out_real(core_out_real), .core_out_img(core_out_img), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Identity core: results are only correct once core_en has been high for L cycles
  always @(posedge clk) en_run <= core_en ? en_run + 1 : 0;
  assign core_out_real = (core_en && en_run == L - 1) ? core_in_real : ~core_in_real;
  assign core_out_img = (core_en && en_run == L - 1) ? core_in_img : ~core_in_img;

  task automatic fill_frame(input bit pattern);
    for (int k = 0; k < N; k++) begin
      frm_re[k] = pattern ? DW'(k) : DW'($urandom);
      frm_im[k] = pattern ? DW'(-k) : DW'($urandom);
    end
  endtask

  task automatic send_frame(input int count, input bit gapped, input bit hold, input logic [DW-1:0] nre, input logic [DW-1:0] nim);
    for (int k = 0; k < count; k++) begin
      int w = 0;
      s_real = frm_re[k];
      s_img = frm_im[k];
      s_valid = 1'b1;
      while (!s_ready && w < 300) begin
        @(negedge clk);
        if (frame_done) fd_cnt++;
        w++;
      end
      if (!s_ready) begin
        checks++; errors++;
        $display("FAIL send_timeout: sample %0d s_ready=%b want 1", k, s_ready);
        s_valid = 1'b0;
        return;
      end
      exp_re.push_back(s_real);
      exp_im.push_back(s_img);
      if (k == 0) first_acc = cyc + 1;
      last_acc = cyc + 1;
      @(negedge clk);
      if (frame_done) fd_cnt++;
      s_valid = 1'b0;
      if (gapped && k < count - 1) begin
        @(negedge clk);
        if (frame_done) fd_cnt++;
      end
    end
    if (hold) begin
      s_valid = 1'b1;
      s_real = nre;
      s_img = nim;
    end
  endtask

  task automatic collect_frame(input int stall_at, input int stall_len);
    int b = 0, budget = 0;
    logic [DW-1:0] sr;
    en_cnt = 0; s_ready_hi = 0; core_in_bad = 0; stall_bad = 0; stall_cnt = 0; stall_idx = -1; first_hs = -1;
    busy_start = busy; cin_re = core_in_real; cin_im = core_in_img; sr = '0;
    while (b < N && budget < L + N + stall_len + 50) begin
      if (core_en) en_cnt++;
      if (core_en && (core_in_real !== cin_re || core_in_img !== cin_im)) core_in_bad++;
      if (s_ready) s_ready_hi++;
      if (m_valid && b == stall_at && stall_cnt < stall_len) begin
        if (stall_cnt == 0) begin
          sr = m_real;
          stall_idx = int'(m_index);
        end else if (m_real !== sr || int'(m_index) != stall_idx) stall_bad++;
        stall_cnt++;
        m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
        if (m_valid) begin
          got_re[b] = m_real; got_im[b] = m_img; got_idx[b] = m_index; got_last[b] = m_last;
          if (b == 0) first_hs = cyc + 1;
          b++;
        end
      end
      @(negedge clk);
      if (frame_done) fd_cnt++;
      budget++;
    end
    m_ready = 1'b1;
    if (b < N) begin
      checks++; errors++;
      $display("FAIL collect_timeout: bins received %0d want %0d", b, N);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    checks++;
    if ({m_valid, m_last, core_en, busy, frame_done} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {m_valid, m_last, core_en, busy, frame_done});
    end
    checks++;
    if (m_index !== '0 || m_real !== '0 || m_img !== '0) begin
      errors++; $display("FAIL reset_data: got idx=%0d %h/%h want 0 0/0", m_index, m_real, m_img);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: got s_ready=%b busy=%b want 1 0", s_ready, busy);
    end
  endtask

  task automatic test_basic;
    logic [N*DW-1:0] pk_re, pk_im;
    fill_frame(1'b1);
    fd_cnt = 0;
    send_frame(N, 1'b0, 1'b0, '0, '0);
    collect_frame(-1, 0);
    for (int k = 0; k < N; k++) begin
      pk_re[k*DW +: DW] = DW'(k);
      pk_im[k*DW +: DW] = DW'(-k);
    end
    checks++;
    if (busy_start !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_start); end
    checks++;
    if (en_cnt != L) begin errors++; $display("FAIL basic_core_en: got %0d cycles want %0d", en_cnt, L); end
    checks++;
    if (first_hs - last_acc != L + 2) begin
      errors++; $display("FAIL basic_latency: got %0d want %0d", first_hs - last_acc, L + 2);
    end
    checks++;
    if (cin_re !== pk_re || cin_im !== pk_im || core_in_bad != 0) begin
      errors++; $display("FAIL basic_core_in: got %h/%h unstable=%0d want %h/%h 0", cin_re, cin_im, core_in_bad, pk_re, pk_im);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_re[k] !== DW'(k) || got_im[k] !== DW'(-k) || got_idx[k] !== IW'(k) || got_last[k] !== (k == N - 1)) begin
        errors++;
        $display("FAIL basic_bin%0d: got %h/%h idx=%0d last=%b want %h/%h idx=%0d last=%b",
                 k, got_re[k], got_im[k], got_idx[k], got_last[k], DW'(k), DW'(-k), k, k == N - 1);
      end
    end
    exp_re.delete(); exp_im.delete();
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || s_ready_hi != 0) begin
      errors++; $display("FAIL basic_done: got frame_done=%b busy=%b s_ready_cycles=%0d want 1 0 0", frame_done, busy, s_ready_hi);
    end
    @(negedge clk);
    if (frame_done) fd_cnt++;
    checks++;
    if (frame_done !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1 || fd_cnt != 1) begin
      errors++; $display("FAIL basic_idle: got frame_done=%b m_valid=%b s_ready=%b pulses=%0d want 0 0 1 1", frame_done, m_valid, s_ready, fd_cnt);
    end
  endtask

  task automatic test_gapped;
    fill_frame(1'b0);
    send_frame(N, 1'b1, 1'b0, '0, '0);
    collect_frame(-1, 0);
    checks++;
    if (last_acc - first_acc + 1 != 2 * N - 1) begin
      errors++; $display("FAIL gapped_load_span: got %0d cycles want %0d", last_acc - first_acc + 1, 2 * N - 1);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k] || got_idx[k] !== IW'(k) || got_last[k] !== (k == N - 1)) begin
        errors++;
        $display("FAIL gapped_bin%0d: got %h/%h idx=%0d last=%b want %h/%h idx=%0d last=%b",
                 k, got_re[k], got_im[k], got_idx[k], got_last[k], exp_re[k], exp_im[k], k, k == N - 1);
      end
    end
    exp_re.delete(); exp_im.delete();
  endtask

  task automatic test_backpressure;
    fill_frame(1'b0);
    send_frame(N, 1'b0, 1'b0, '0, '0);
    collect_frame(7, 5);
    checks++;
    if (stall_cnt != 5 || stall_idx != 7 || stall_bad != 0) begin
      errors++; $display("FAIL stall_hold: got cycles=%0d idx=%0d changes=%0d want 5 7 0", stall_cnt, stall_idx, stall_bad);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k] || got_idx[k] !== IW'(k) || got_last[k] !== (k == N - 1)) begin
        errors++;
        $display("FAIL stall_bin%0d: got %h/%h idx=%0d last=%b want %h/%h idx=%0d last=%b",
                 k, got_re[k], got_im[k], got_idx[k], got_last[k], exp_re[k], exp_im[k], k, k == N - 1);
      end
    end
    exp_re.delete(); exp_im.delete();
  endtask

  task automatic test_reset_midframe;
    fill_frame(1'b0);
    send_frame(10, 1'b0, 1'b0, '0, '0);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, busy, core_en, m_valid, frame_done} !== 5'b0 || m_index !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %b idx=%0d want 00000 idx=0", {s_ready, busy, core_en, m_valid, frame_done}, m_index);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_re.delete(); exp_im.delete();
    fd_cnt = 0;
    fill_frame(1'b0);
    send_frame(N, 1'b0, 1'b0, '0, '0);
    collect_frame(-1, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k] || got_idx[k] !== IW'(k) || got_last[k] !== (k == N - 1)) begin
        errors++;
        $display("FAIL midreset_bin%0d: got %h/%h idx=%0d last=%b want %h/%h idx=%0d last=%b",
                 k, got_re[k], got_im[k], got_idx[k], got_last[k], exp_re[k], exp_im[k], k, k == N - 1);
      end
    end
    exp_re.delete(); exp_im.delete();
    checks++;
    if (fd_cnt != 1) begin errors++; $display("FAIL midreset_done: got %0d pulses want 1", fd_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] nre, nim;
    fd_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) fill_frame(1'b0);
      else begin
        fill_frame(1'b0);
        frm_re[0] = nre;
        frm_im[0] = nim;
      end
      nre = DW'($urandom);
      nim = DW'($urandom);
      send_frame(N, 1'b0, f == 0, nre, nim);
      collect_frame(-1, 0);
      checks++;
      if (s_ready_hi != 0) begin errors++; $display("FAIL b2b_s_ready%0d: got %0d high cycles want 0", f, s_ready_hi); end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k] || got_idx[k] !== IW'(k) || got_last[k] !== (k == N - 1)) begin
          errors++;
          $display("FAIL b2b_f%0d_bin%0d: got %h/%h idx=%0d last=%b want %h/%h idx=%0d last=%b",
                   f, k, got_re[k], got_im[k], got_idx[k], got_last[k], exp_re[k], exp_im[k], k, k == N - 1);
        end
      end
      exp_re.delete(); exp_im.delete();
    end
    s_valid = 1'b0;
    @(negedge clk);
    if (frame_done) fd_cnt++;
    checks++;
    if (fd_cnt != 2) begin errors++; $display("FAIL b2b_done: got %0d pulses want 2", fd_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gapped;
    test_backpressure;
    test_reset_midframe;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
